// File: rtl/hamming16_encoder_pipe_if.sv
// Handshake and data bundle for the Hamming(21,16) encoder pipe.
// Under HAM_SECDED_EN the codeword bus widens to 22 bits to carry the overall parity bit.
interface hamming16_encoder_pipe_if #(
  parameter int CNT_W = 16
);
`ifdef HAM_SECDED_EN
  localparam int CW_W = 22;
`else
  localparam int CW_W = 21;
`endif

  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             inject_en;
  logic [4:0]       inject_pos;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      d_out;
  logic [4:0]       p_out;
  logic [CW_W-1:0]  cw_out;
  logic [CNT_W-1:0] enc_count;

  modport master (
    output in_valid, in_data, inject_en, inject_pos, out_ready,
    input  in_ready, out_valid, d_out, p_out, cw_out, enc_count
  );

  modport slave (
    input  in_valid, in_data, inject_en, inject_pos, out_ready,
    output in_ready, out_valid, d_out, p_out, cw_out, enc_count
  );
endinterface

// File: rtl/hamming16_encoder_pipe.sv
// Two-stage Hamming(21,16) encoder with valid/ready flow, per-word bit-flip injection and transfer counter.
// Define HAM_SECDED_EN to append an overall-parity bit (cw_out becomes 22 bits, injectable at index 21).
module hamming16_encoder_pipe #(
  parameter int CNT_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  hamming16_encoder_pipe_if.slave bus
);
`ifdef HAM_SECDED_EN
  localparam int CW_W = 22;
`else
  localparam int CW_W = 21;
`endif
  localparam logic [4:0] CW_W5 = 5'(CW_W);

  // Coverage masks over codeword bits: bit i (position i+1) is in group k when position bit k is set.
  localparam logic [20:0] MASK0 = 21'h15_5555;
  localparam logic [20:0] MASK1 = 21'h06_6666;
  localparam logic [20:0] MASK2 = 21'h18_7878;
  localparam logic [20:0] MASK3 = 21'h00_7F80;
  localparam logic [20:0] MASK4 = 21'h1F_8000;

  function automatic logic [20:0] place(input logic [15:0] d, input logic [4:0] p);
    place = {d[15:11], p[4], d[10:4], p[3], d[3:1], p[2], d[0], p[1], p[0]};
  endfunction

  function automatic logic [4:0] parity(input logic [15:0] d);
    logic [20:0] raw;
    raw = place(d, 5'b0);
    parity = {^(raw & MASK4), ^(raw & MASK3), ^(raw & MASK2), ^(raw & MASK1), ^(raw & MASK0)};
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [15:0]      s1_data_q, s1_data_d;
  logic [4:0]       s1_par_q, s1_par_d;
  logic             s1_inj_q, s1_inj_d;
  logic [4:0]       s1_pos_q, s1_pos_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      d_out_q, d_out_d;
  logic [4:0]       p_out_q, p_out_d;
  logic [CW_W-1:0]  cw_q, cw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s2_free, s1_free, in_ready, accept, advance, xfer;
  logic [20:0]      cw_base;
  logic [CW_W-1:0]  cw_full, flip_mask, cw_inj;

  always_comb begin
    s2_free = !out_valid_q || bus.out_ready;
    s1_free = !s1_valid_q || s2_free;
    in_ready = s1_free && !rst;
    accept = bus.in_valid && in_ready;
    advance = s1_valid_q && s2_free;
    xfer = out_valid_q && bus.out_ready;

    s1_valid_d = s1_valid_q;
    s1_data_d = s1_data_q;
    s1_par_d = s1_par_q;
    s1_inj_d = s1_inj_q;
    s1_pos_d = s1_pos_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d = bus.in_data;
      s1_par_d = parity(bus.in_data);
      s1_inj_d = bus.inject_en;
      s1_pos_d = bus.inject_pos;
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end

    cw_base = place(s1_data_q, s1_par_q);
`ifdef HAM_SECDED_EN
    cw_full = {^cw_base, cw_base};
`else
    cw_full = cw_base;
`endif
    flip_mask = '0;
    if (s1_inj_q && (s1_pos_q < CW_W5)) flip_mask[s1_pos_q] = 1'b1;
    cw_inj = cw_full ^ flip_mask;

    out_valid_d = out_valid_q;
    d_out_d = d_out_q;
    p_out_d = p_out_q;
    cw_d = cw_q;
    if (advance) begin
      out_valid_d = 1'b1;
      cw_d = cw_inj;
      // Split view comes from the injected word so a flip lands where the decoder will see it.
      d_out_d = {cw_inj[20:16], cw_inj[14:8], cw_inj[6:4], cw_inj[2]};
      p_out_d = {cw_inj[15], cw_inj[7], cw_inj[3], cw_inj[1], cw_inj[0]};
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    cnt_d = cnt_q + CNT_W'(xfer);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_par_q    <= '0;
      s1_inj_q    <= 1'b0;
      s1_pos_q    <= '0;
      out_valid_q <= 1'b0;
      d_out_q     <= '0;
      p_out_q     <= '0;
      cw_q        <= '0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_par_q    <= s1_par_d;
      s1_inj_q    <= s1_inj_d;
      s1_pos_q    <= s1_pos_d;
      out_valid_q <= out_valid_d;
      d_out_q     <= d_out_d;
      p_out_q     <= p_out_d;
      cw_q        <= cw_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.d_out     = d_out_q;
  assign bus.p_out     = p_out_q;
  assign bus.cw_out    = cw_q;
  assign bus.enc_count = cnt_q;
endmodule
